// File: rtl/sipo_frame_rx.sv
// -----------------------------------------------------------------------------
// sipo_frame_rx
// Serial-in / parallel-out frame receiver. It samples one line bit per clock and
// recovers frames of the form: start(0), WIDTH data bits LSB first, optional
// parity bit, stop(1). Recovered words are held on a valid/ready output.
//
// Ports
//   clk            system clock, rising edge
//   reset_ah_in    asynchronous active-high reset
//   d_in           serial line, idles high
//   rd_ready_in    consumer accepts q_out on an edge where q_valid_out=1
//   q_out          received word, bit 0 = first data bit on the line
//   q_valid_out    q_out holds an unconsumed word
//   parity_err_out parity status of the word on q_out (valid with q_valid_out)
//   frame_err_out  one-cycle pulse when a stop bit is sampled 0
//   overrun_out    sticky: a good word was dropped because q_out was still full
//   busy_out       FSM is not idle
// -----------------------------------------------------------------------------
module sipo_frame_rx #(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             reset_ah_in,
   input  logic             d_in,
   input  logic             rd_ready_in,
   output logic [WIDTH-1:0] q_out,
   output logic             q_valid_out,
   output logic             parity_err_out,
   output logic             frame_err_out,
   output logic             overrun_out,
   output logic             busy_out
);

   localparam int             CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);
   localparam logic           P_EN  = (PARITY_EN != 0);
   localparam logic           P_ODD = (PARITY_ODD != 0);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_pbit;
   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic             r_perr;
   logic             r_frame_err;
   logic             r_overrun;
   logic             r_busy;

   logic             w_perr;

   // Parity of the assembled word, evaluated while sitting in StStop.
   assign w_perr = P_EN & ((^r_shift) ^ r_pbit ^ P_ODD);

   always_ff @(posedge clk or posedge reset_ah_in) begin
      if (reset_ah_in) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_pbit      <= 1'b0;
         r_q         <= '0;
         r_q_valid   <= 1'b0;
         r_perr      <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         // Consumption by default; a good stop bit below may reload on the same edge.
         if (r_q_valid && rd_ready_in) begin
            r_q_valid <= 1'b0;
         end
         case (r_state)
            StIdle: begin
               if (!d_in) begin
                  r_state <= StData;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            StData: begin
               r_shift <= {d_in, r_shift[WIDTH-1:1]};
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= P_EN ? StParity : StStop;
               end
            end
            StParity: begin
               r_pbit  <= d_in;
               r_state <= StStop;
            end
            StStop: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
               if (d_in) begin
                  if (!r_q_valid || rd_ready_in) begin
                     r_q       <= r_shift;
                     r_perr    <= w_perr;
                     r_q_valid <= 1'b1;
                  end else begin
                     r_overrun <= 1'b1;
                  end
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign q_out          = r_q;
   assign q_valid_out    = r_q_valid;
   assign parity_err_out = r_perr;
   assign frame_err_out  = r_frame_err;
   assign overrun_out    = r_overrun;
   assign busy_out       = r_busy;

endmodule

// File: tb/tb_sipo_frame_rx.sv
module tb_sipo_frame_rx;

   logic       clk;
   logic       reset_ah_in;
   logic       d_in;
   logic       rd_ready_in;
   logic [7:0] q_out;
   logic       q_valid_out;
   logic       parity_err_out;
   logic       frame_err_out;
   logic       overrun_out;
   logic       busy_out;

   int n_checks = 0;
   int n_pass   = 0;

   sipo_frame_rx #(
      .WIDTH     (8),
      .PARITY_EN (1),
      .PARITY_ODD(0)
   ) u_dut (
      .clk           (clk),
      .reset_ah_in   (reset_ah_in),
      .d_in          (d_in),
      .rd_ready_in   (rd_ready_in),
      .q_out         (q_out),
      .q_valid_out   (q_valid_out),
      .parity_err_out(parity_err_out),
      .frame_err_out (frame_err_out),
      .overrun_out   (overrun_out),
      .busy_out      (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Concatenation of every output, for all-zero checks.
   function automatic logic [31:0] all_outs();
      return {18'd0, q_out, q_valid_out, parity_err_out, frame_err_out, overrun_out, busy_out};
   endfunction

   // Drives one frame. With chk_lat set, checks q_valid is still low just
   // before the stop edge. With rdy_at_stop set, rd_ready_in is raised only
   // for the stop edge.
   task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop,
                             input logic chk_lat, input logic rdy_at_stop);
      d_in = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         d_in = data[i];
         tick();
      end
      d_in = pbit;
      tick();
      if (chk_lat) check("latency_k9_valid_low", {31'd0, q_valid_out}, 32'd0);
      d_in = stop;
      if (rdy_at_stop) rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
      d_in = 1'b1;
   endtask

   initial begin
      reset_ah_in = 1'b1;
      d_in        = 1'b1;
      rd_ready_in = 1'b0;

      // Reset and idle line
      #1;
      check("reset_outs", all_outs(), 32'd0);
      tick(); tick(); tick();
      reset_ah_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_outs", all_outs(), 32'd0);
      end

      // Good 0xA5, correct parity, latency k+10
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
      check("a5_valid", {31'd0, q_valid_out}, 32'd1);
      check("a5_data", {24'd0, q_out}, 32'hA5);
      check("a5_perr", {31'd0, parity_err_out}, 32'd0);
      check("a5_busy", {31'd0, busy_out}, 32'd0);
      tick();
      check("a5_hold", {24'd0, q_out}, 32'hA5);
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
      check("a5_consumed", {31'd0, q_valid_out}, 32'd0);

      // 0xA5 with wrong parity bit
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
      check("perr_valid", {31'd0, q_valid_out}, 32'd1);
      check("perr_data", {24'd0, q_out}, 32'hA5);
      check("perr_flag", {31'd0, parity_err_out}, 32'd1);
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
      check("perr_consumed", {31'd0, q_valid_out}, 32'd0);

      // Framing error on 0x3C, then 0x81 back-to-back
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ferr_pulse", {31'd0, frame_err_out}, 32'd1);
      check("ferr_no_valid", {31'd0, q_valid_out}, 32'd0);
      check("ferr_no_ovr", {31'd0, overrun_out}, 32'd0);
      check("ferr_q_kept", {24'd0, q_out}, 32'hA5);
      send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
      check("b2b_81_valid", {31'd0, q_valid_out}, 32'd1);
      check("b2b_81_data", {24'd0, q_out}, 32'h81);
      check("b2b_81_ferr_low", {31'd0, frame_err_out}, 32'd0);
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
      check("b2b_81_consumed", {31'd0, q_valid_out}, 32'd0);

      // Overrun: 0xA5 then 0x3C without consuming
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ovr_none_yet", {31'd0, overrun_out}, 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ovr_flag", {31'd0, overrun_out}, 32'd1);
      check("ovr_data_kept", {24'd0, q_out}, 32'hA5);
      check("ovr_valid", {31'd0, q_valid_out}, 32'd1);
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
      check("ovr_consumed", {31'd0, q_valid_out}, 32'd0);
      tick();
      check("ovr_sticky", {31'd0, overrun_out}, 32'd1);

      // Simultaneous consume and reload
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      check("hold_11", {24'd0, q_out}, 32'h11);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
      check("reload_valid", {31'd0, q_valid_out}, 32'd1);
      check("reload_data", {24'd0, q_out}, 32'h22);
      tick();
      check("reload_stable", {24'd0, q_out}, 32'h22);

      // Asynchronous reset mid-frame
      d_in = 1'b0;
      tick();
      d_in = 1'b1; tick();
      d_in = 1'b0; tick();
      d_in = 1'b1; tick();
      d_in = 1'b0; tick();
      check("mid_busy", {31'd0, busy_out}, 32'd1);
      #2;
      reset_ah_in = 1'b1;
      #1;
      check("async_reset_outs", all_outs(), 32'd0);
      d_in = 1'b1;
      tick();
      reset_ah_in = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("post_reset_outs", all_outs(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
